// File: rtl/iob_pcie_tx_engine_if.sv
// rtl/iob_pcie_tx_engine_if.sv - PCIe core TX channel bundle between engine (master) and core (slave)
interface iob_pcie_tx_engine_if #(
  parameter int LEN_W      = 32,
  parameter int PCI_DATA_W = 64
);
  logic                  chnl_tx_o;
  logic                  chnl_tx_last_o;
  logic [LEN_W-1:0]      chnl_tx_len_o;
  logic [30:0]           chnl_tx_off_o;
  logic [PCI_DATA_W-1:0] chnl_tx_data_o;
  logic                  chnl_tx_data_valid_o;
  logic                  chnl_tx_data_ren_i;
  logic                  chnl_tx_ack_i;

  modport master (
    output chnl_tx_o, chnl_tx_last_o, chnl_tx_len_o, chnl_tx_off_o,
    output chnl_tx_data_o, chnl_tx_data_valid_o,
    input  chnl_tx_data_ren_i, chnl_tx_ack_i
  );

  modport slave (
    input  chnl_tx_o, chnl_tx_last_o, chnl_tx_len_o, chnl_tx_off_o,
    input  chnl_tx_data_o, chnl_tx_data_valid_o,
    output chnl_tx_data_ren_i, chnl_tx_ack_i
  );
endinterface

// File: rtl/iob_pcie_tx_engine.sv
// rtl/iob_pcie_tx_engine.sv - packs CPU words into PCI beats, buffers them and runs the channel TX transaction
module iob_pcie_tx_engine #(
  parameter int DATA_W      = 32,
  parameter int PCI_DATA_W  = 64,
  parameter int FIFO_ADDR_W = 4,
  parameter int LEN_W       = 32,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic                   last_i,
  input  logic [30:0]            off_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  input  logic                   wr_en_i,
  output logic                   wr_full_o,
  output logic [FIFO_ADDR_W:0]   level_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  iob_pcie_tx_engine_if.master   chnl
);
  localparam int RATIO  = PCI_DATA_W / DATA_W;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DEPTH  = 2 ** FIFO_ADDR_W;
  localparam logic [FIFO_ADDR_W:0] LVL_FULL   = (FIFO_ADDR_W+1)'(DEPTH);
  localparam logic [FIFO_ADDR_W:0] LVL_ALMOST = (FIFO_ADDR_W+1)'(DEPTH - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST   = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  typedef enum logic [1:0] {IDLE, REQ, SEND, ABORT} state_t;
  state_t state_q, state_d;

  logic [LEN_W-1:0]       len_q, words_in_q, beats_sent_q, beats_total;
  logic                   last_q, done_q, pend_q, full_q;
  logic [30:0]            off_q;
  logic [TIMEOUT_W-1:0]   tmo_q;
  logic [PCI_DATA_W-1:0]  pack_q, pack_nxt, beat_q;
  logic [PCI_DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_W:0]   level_q, level_d;
  logic [LANE_W-1:0]      lane;
  logic                   open_req, wr_acc, beat_done, valid, pop, last_pop;

  assign open_req    = (state_q == IDLE) & start_i & (len_i != '0);
  assign lane        = words_in_q[LANE_W-1:0];
  // A pending push into a FIFO with one free slot must not be joined by further words.
  assign wr_acc      = ((state_q == REQ) | (state_q == SEND)) & wr_en_i & ~full_q &
                       ~(pend_q & (level_q == LVL_ALMOST)) & (words_in_q < len_q);
  assign beat_done   = wr_acc & ((lane == LANE_W'(RATIO - 1)) | (words_in_q + LEN_W'(1) == len_q));
  assign valid       = (state_q == SEND) & (level_q != '0);
  assign pop         = valid & chnl.chnl_tx_data_ren_i;
  assign beats_total = (len_q >> LANE_W) + LEN_W'(|len_q[LANE_W-1:0]);
  assign last_pop    = pop & (beats_sent_q + LEN_W'(1) == beats_total);
  assign level_d     = level_q + (FIFO_ADDR_W+1)'(pend_q) - (FIFO_ADDR_W+1)'(pop);

  always_comb begin
    pack_nxt = pack_q;
    for (int i = 0; i < RATIO; i++)
      if (lane == LANE_W'(i)) pack_nxt[i*DATA_W +: DATA_W] = wr_data_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (open_req) state_d = REQ;
      REQ:     if (chnl.chnl_tx_ack_i) state_d = SEND;
               else if (tmo_q == TMO_LAST) state_d = ABORT;
      SEND:    if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      last_q       <= 1'b0;
      off_q        <= '0;
      words_in_q   <= '0;
      beats_sent_q <= '0;
      tmo_q        <= '0;
      pack_q       <= '0;
      beat_q       <= '0;
      pend_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_pop;
      pend_q  <= beat_done;
      if (open_req) begin
        len_q        <= len_i;
        last_q       <= last_i;
        off_q        <= off_i;
        words_in_q   <= '0;
        beats_sent_q <= '0;
        tmo_q        <= '0;
        pack_q       <= '0;
      end
      if (state_q == REQ) tmo_q <= tmo_q + TIMEOUT_W'(1);
      if (wr_acc) begin
        words_in_q <= words_in_q + LEN_W'(1);
        if (beat_done) begin
          beat_q <= pack_nxt;
          pack_q <= '0;
        end else begin
          pack_q <= pack_nxt;
        end
      end
      if (pop) begin
        beats_sent_q <= beats_sent_q + LEN_W'(1);
        rd_ptr_q     <= rd_ptr_q + FIFO_ADDR_W'(1);
      end
      if (pend_q) wr_ptr_q <= wr_ptr_q + FIFO_ADDR_W'(1);
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      // Abort discards everything buffered, including a partly packed beat.
      if (state_q == ABORT) begin
        pack_q   <= '0;
        pend_q   <= 1'b0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        full_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pend_q) mem[wr_ptr_q] <= beat_q;
  end

  assign busy_o    = (state_q != IDLE);
  assign err_o     = (state_q == ABORT);
  assign done_o    = done_q;
  assign wr_full_o = full_q;
  assign level_o   = level_q;

  assign chnl.chnl_tx_o            = (state_q == REQ) | (state_q == SEND);
  assign chnl.chnl_tx_last_o       = last_q;
  assign chnl.chnl_tx_len_o        = len_q;
  assign chnl.chnl_tx_off_o        = off_q;
  assign chnl.chnl_tx_data_valid_o = valid;
  assign chnl.chnl_tx_data_o       = valid ? mem[rd_ptr_q] : '0;
endmodule

// File: doc/iob_pcie_tx_engine.md
Name: iob_pcie_tx_engine

Overview:
Single-clock, parametrised PCIe TX channel engine. It packs CPU-side DATA_W words into PCI_DATA_W beats and buffers them in an internal FIFO. It sequences the full channel TX transaction: request, ack wait, data streaming, completion/abort. It sits between the iob_pcie software registers and the PCIe core channel. It generalises the register-driven TX path to any PCI width and FIFO depth, and adds length tracking, auto-deassertion and an ack timeout.

Parameters:
DATA_W, 32, CPU write word width; fixed 32 (channel length unit).
PCI_DATA_W, 64, channel data width; 64, 128 or 256; RATIO = PCI_DATA_W/DATA_W.
FIFO_ADDR_W, 4, FIFO depth = 2**FIFO_ADDR_W beats of PCI_DATA_W.
LEN_W, 32, transaction length width in 32-bit words.
TIMEOUT_W, 16, ack-timeout counter width; limit = 2**TIMEOUT_W-1 cycles.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start_i  in  1  one-cycle request to open a transaction
len_i  in  LEN_W  transaction length in 32-bit words, sampled on start_i
last_i  in  1  last-in-sequence flag, sampled on start_i
off_i  in  31  offset in 32-bit words, sampled on start_i
wr_data_i  in  DATA_W  CPU data word
wr_en_i  in  1  CPU write strobe
wr_full_o  out  1  FIFO cannot accept a completed beat
level_o  out  FIFO_ADDR_W+1  FIFO occupancy in beats
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse, transaction completed
err_o  out  1  one-cycle pulse, ack timeout abort
chnl_tx_o  out  1  channel TX request
chnl_tx_last_o  out  1  latched last_i
chnl_tx_len_o  out  LEN_W  latched len_i
chnl_tx_off_o  out  31  latched off_i
chnl_tx_data_o  out  PCI_DATA_W  FIFO head (first-word fall-through)
chnl_tx_data_valid_o  out  1  head valid
chnl_tx_data_ren_i  in  1  core consumes head when high with valid
chnl_tx_ack_i  in  1  core acknowledges transaction

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO empty, pack register/counters cleared, state IDLE. Reset mid-transaction discards all data. No done_o or err_o is pulsed.
- States:
  - IDLE: start_i with len_i != 0 latches len/last/off, clears counters, and enters REQ. start_i with len_i == 0 is ignored. start_i outside IDLE is ignored.
  - REQ: chnl_tx_o=1; timeout counter increments every cycle. chnl_tx_ack_i moves to SEND.
  - Timeout: the counter hitting the limit moves to ABORT.
  - SEND: chnl_tx_o=1, data streamed.
  - ABORT: one cycle. Flush FIFO and pack register, err_o=1, go to IDLE.
- CPU writes are accepted only when busy_o=1, wr_en_i=1, wr_full_o=0, and words_in < len. All other writes are dropped silently. Writes are accepted in REQ, so data can be prefetched before the ack.
- Packing: accepted words fill the pack register little-endian; word k goes to bits [32*(k mod RATIO) +: 32]. A beat is pushed when RATIO words have been collected, or when words_in reaches len. A final partial beat is zero-padded in the upper lanes. The push happens the cycle after the completing write.
- wr_full_o = (level_o == depth). It is registered and updated the same cycle as level.
- chnl_tx_data_valid_o = (state == SEND) & ~fifo_empty.
- Pop rule: a pop occurs when chnl_tx_data_valid_o & chnl_tx_data_ren_i. The next head is presented in the following cycle.
- Simultaneous push and pop: level unchanged. Both are legal at full and at empty+pending push.
- beats_total = ceil(len/RATIO). When the beat_sent count reaches beats_total, the next state is IDLE. chnl_tx_o drops in the cycle after the final pop, and done_o pulses in that same cycle.
- Counters: words_in/beats_sent are LEN_W wide. No wrap is possible because writes beyond len are dropped.
- chnl_tx_len_o/off_o/last_o hold their latched values until the next accepted start_i.

Test Plan:
- PCI_DATA_W=64, start len=4; write 0x11,0x22,0x33,0x44; ack after 3 cycles; ren held 1 -> beats 0x00000022_00000011 then 0x00000044_00000033; done_o pulses once; chnl_tx_o low the cycle after the 2nd pop.
- len=3, PCI_DATA_W=64 -> 2 beats, 2nd = 0x00000000_00000033 (zero-padded); a 4th write is dropped and level_o stays 0 after completion.
- PCI_DATA_W=128, FIFO_ADDR_W=2, len=32, ren=0 after ack -> wr_full_o=1 after 16 writes, extra writes dropped; then ren=1 -> all 8 beats delivered in order, done_o=1.
- No ack, TIMEOUT_W=4 -> err_o pulses at cycle 15 after REQ entry; FIFO flushed; busy_o=0; chnl_tx_o=0.
- start len=0 -> no state change; start_i during SEND ignored (latched len unchanged).
- rst asserted mid-SEND with 3 beats buffered -> outputs 0 immediately, level_o=0, no done_o; a fresh len=2 transaction then completes normally.
